// File: rtl/tnn_column_stdp.sv
// tnn_column_stdp
//   Temporal-neural-network column. Accepts one spike volley per gamma cycle,
//   integrates step-no-leak potentials over T_PERIOD time steps, picks the
//   earliest-firing neuron (1-WTA, ties to lowest index) and optionally applies
//   deterministic STDP, one neuron per cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        volley handshake; in_times packs NUM_INPUTS spike
//                            times of TW bits (MSB=1 means no spike)
//   learn_en                 sampled with the volley, enables STDP for it
//   out_valid/out_ready      result handshake
//   out_time, out_winner     winner spike time (MSB=1: none) and index
//   wr_en/wr_neuron/wr_input/wr_data   weight write, honoured only in IDLE
//   busy                     column is not idle
module tnn_column_stdp #(
    parameter int NUM_INPUTS  = 16,
    parameter int NUM_NEURONS = 4,
    parameter int T_PERIOD    = 8,
    parameter int WBITS       = 3,
    parameter int THRESH      = 12,
    parameter int WINIT       = 1,
    localparam int TW = $clog2(T_PERIOD) + 1,
    localparam int NB = $clog2(NUM_NEURONS),
    localparam int IB = $clog2(NUM_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_INPUTS*TW-1:0] in_times,
    input  logic                     learn_en,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TW-1:0]            out_time,
    output logic [NB-1:0]            out_winner,
    input  logic                     wr_en,
    input  logic [NB-1:0]            wr_neuron,
    input  logic [IB-1:0]            wr_input,
    input  logic [WBITS-1:0]         wr_data,
    output logic                     busy
);

    localparam int TCW = TW - 1;
    localparam int PW  = WBITS + IB + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_LEARN   = 2'd2;
    localparam logic [1:0] S_OUT     = 2'd3;

    logic [1:0]               state_q, state_d;
    logic [TCW-1:0]           t_q, t_d;
    logic [NB-1:0]            lcnt_q, lcnt_d;
    logic [NUM_INPUTS*TW-1:0] times_q, times_d;
    logic                     learn_q, learn_d;
    logic [NUM_NEURONS-1:0]   fired_q, fired_d;
    logic [TCW-1:0]           ftime_q [NUM_NEURONS];
    logic [TCW-1:0]           ftime_d [NUM_NEURONS];
    logic [TW-1:0]            out_time_q, out_time_d;
    logic [NB-1:0]            out_winner_q, out_winner_d;
    logic [WBITS-1:0]         w_q [NUM_NEURONS][NUM_INPUTS];
    logic [WBITS-1:0]         w_d [NUM_NEURONS][NUM_INPUTS];

    logic [NUM_INPUTS-1:0]    spk;   // input carries a usable spike
    logic [NUM_INPUTS-1:0]    act;   // spike has arrived by time t_q
    logic [PW-1:0]            pot [NUM_NEURONS];
    logic                     best_found;
    logic [TCW-1:0]           best_time;
    logic [NB-1:0]            best_idx;
    logic                     post;

    assign in_ready   = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_OUT);
    assign out_time   = out_time_q;
    assign out_winner = out_winner_q;

    // Potentials are recomputed each step from the arrived inputs; with no leak
    // this equals the running accumulation.
    always_comb begin
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            spk[i] = !times_q[i*TW + TW - 1] &&
                     (int'(times_q[i*TW +: TCW]) < T_PERIOD);
            act[i] = spk[i] && (times_q[i*TW +: TCW] <= t_q);
        end
        for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
            pot[j] = '0;
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (act[i]) pot[j] = pot[j] + PW'(w_q[j][i]);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        t_d          = t_q;
        lcnt_d       = lcnt_q;
        times_d      = times_q;
        learn_d      = learn_q;
        fired_d      = fired_q;
        ftime_d      = ftime_q;
        out_time_d   = out_time_q;
        out_winner_d = out_winner_q;
        w_d          = w_q;
        best_found   = 1'b0;
        best_time    = '0;
        best_idx     = '0;
        post         = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Write lands in w_q at the accept edge, so the volley sees it.
                for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
                    for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                        if (wr_en && wr_neuron == NB'(j) && wr_input == IB'(i))
                            w_d[j][i] = wr_data;
                    end
                end
                if (in_valid) begin
                    times_d = in_times;
                    learn_d = learn_en;
                    fired_d = '0;
                    t_d     = '0;
                    state_d = S_COMPUTE;
                end
            end

            S_COMPUTE: begin
                for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
                    if (!fired_q[j] && int'(pot[j]) >= THRESH) begin
                        fired_d[j] = 1'b1;
                        ftime_d[j] = t_q;
                    end
                end
                if (t_q == TCW'(T_PERIOD - 1)) begin
                    // WTA over next-state flags so a last-step firing counts;
                    // strict '<' keeps the lowest index on ties.
                    for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
                        if (fired_d[j] && (!best_found || ftime_d[j] < best_time)) begin
                            best_found = 1'b1;
                            best_time  = ftime_d[j];
                            best_idx   = NB'(j);
                        end
                    end
                    out_time_d   = best_found ? {1'b0, best_time} : {1'b1, {TCW{1'b0}}};
                    out_winner_d = best_idx;
                    lcnt_d       = '0;
                    state_d      = learn_q ? S_LEARN : S_OUT;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end

            S_LEARN: begin
                post = (lcnt_q == out_winner_q) && !out_time_q[TW-1];
                for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
                    if (lcnt_q == NB'(j)) begin
                        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                            if (post) begin
                                if (spk[i] && times_q[i*TW +: TCW] <= out_time_q[TCW-1:0]) begin
                                    if (w_q[j][i] != '1) w_d[j][i] = w_q[j][i] + 1'b1;
                                end else begin
                                    if (w_q[j][i] != '0) w_d[j][i] = w_q[j][i] - 1'b1;
                                end
                            end else if (spk[i]) begin
                                if (w_q[j][i] != '1) w_d[j][i] = w_q[j][i] + 1'b1;
                            end
                        end
                    end
                end
                if (lcnt_q == NB'(NUM_NEURONS - 1)) state_d = S_OUT;
                else lcnt_d = lcnt_q + 1'b1;
            end

            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            t_q          <= '0;
            lcnt_q       <= '0;
            times_q      <= '0;
            learn_q      <= 1'b0;
            fired_q      <= '0;
            out_time_q   <= {1'b1, {TCW{1'b0}}};
            out_winner_q <= '0;
            for (int unsigned j = 0; j < NUM_NEURONS; j++) begin
                ftime_q[j] <= '0;
                for (int unsigned i = 0; i < NUM_INPUTS; i++)
                    w_q[j][i] <= WBITS'(WINIT);
            end
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            lcnt_q       <= lcnt_d;
            times_q      <= times_d;
            learn_q      <= learn_d;
            fired_q      <= fired_d;
            ftime_q      <= ftime_d;
            out_time_q   <= out_time_d;
            out_winner_q <= out_winner_d;
            w_q          <= w_d;
        end
    end

endmodule

// File: tb/tb_tnn_column_stdp.sv
// Testbench for tnn_column_stdp with P=4, Q=2, T=8, THRESH=3, WINIT=1.
module tb_tnn_column_stdp;

    localparam int P    = 4;
    localparam int Q    = 2;
    localparam int T    = 8;
    localparam int WB   = 3;
    localparam int TH   = 3;
    localparam int WI   = 1;
    localparam int TW   = 4;
    localparam int WMAX = 7;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [P*TW-1:0] in_times;
    logic            learn_en;
    logic            out_valid;
    logic            out_ready;
    logic [TW-1:0]   out_time;
    logic [0:0]      out_winner;
    logic            wr_en;
    logic [0:0]      wr_neuron;
    logic [1:0]      wr_input;
    logic [WB-1:0]   wr_data;
    logic            busy;

    always #5 clk = ~clk;

    tnn_column_stdp #(
        .NUM_INPUTS (P),
        .NUM_NEURONS(Q),
        .T_PERIOD   (T),
        .WBITS      (WB),
        .THRESH     (TH),
        .WINIT      (WI)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_times  (in_times),
        .learn_en  (learn_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_time  (out_time),
        .out_winner(out_winner),
        .wr_en     (wr_en),
        .wr_neuron (wr_neuron),
        .wr_input  (wr_input),
        .wr_data   (wr_data),
        .busy      (busy)
    );

    typedef struct {
        logic [TW-1:0] t;
        logic [0:0]    w;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   mw [Q][P];   // bench weight model
    int   sv [P];      // spike times of the next volley, -1 = none

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [P*TW-1:0] pack();
        logic [P*TW-1:0] v;
        for (int i = 0; i < P; i++)
            v[i*TW +: TW] = (sv[i] < 0) ? 4'b1000 : TW'(sv[i]);
        return v;
    endfunction

    // Reference column: fire times, WTA, then STDP on the model weights.
    task automatic model_volley(input bit learn, output exp_t e);
        int ft [Q];
        int win, wt, pot;
        bit sp, post;
        for (int j = 0; j < Q; j++) begin
            ft[j] = -1;
            for (int t = 0; t < T; t++) begin
                if (ft[j] < 0) begin
                    pot = 0;
                    for (int i = 0; i < P; i++)
                        if (sv[i] >= 0 && sv[i] < T && sv[i] <= t) pot += mw[j][i];
                    if (pot >= TH) ft[j] = t;
                end
            end
        end
        win = 0;
        wt  = -1;
        for (int j = 0; j < Q; j++)
            if (ft[j] >= 0 && (wt < 0 || ft[j] < wt)) begin
                win = j;
                wt  = ft[j];
            end
        e.t   = (wt < 0) ? 4'b1000 : TW'(wt);
        e.w   = 1'(win);
        e.lat = learn ? T + Q + 1 : T + 1;
        if (learn) begin
            for (int k = 0; k < Q; k++) begin
                post = (k == win) && (wt >= 0);
                for (int i = 0; i < P; i++) begin
                    sp = (sv[i] >= 0) && (sv[i] < T);
                    if (post) begin
                        if (sp && sv[i] <= wt) mw[k][i] = (mw[k][i] < WMAX) ? mw[k][i] + 1 : WMAX;
                        else                   mw[k][i] = (mw[k][i] > 0) ? mw[k][i] - 1 : 0;
                    end else if (sp) begin
                        mw[k][i] = (mw[k][i] < WMAX) ? mw[k][i] + 1 : WMAX;
                    end
                end
            end
        end
    endtask

    task automatic check_weights(input string tag);
        for (int j = 0; j < Q; j++)
            for (int i = 0; i < P; i++)
                check(tag, 32'(dut.w_q[j][i]), 32'(mw[j][i]));
    endtask

    task automatic write_w(input int j, input int i, input int d);
        wr_en     = 1'b1;
        wr_neuron = 1'(j);
        wr_input  = 2'(i);
        wr_data   = WB'(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        mw[j][i] = d;
    endtask

    // Drive one volley (optionally with a same-cycle weight write), then
    // collect the result from the scoreboard. hold>0 stalls out_ready.
    task automatic run_volley(input string tag, input bit learn, input bit with_wr,
                              input int wj, input int wi, input int wd, input int hold);
        exp_t e, got;
        int   lat;
        logic [TW-1:0] t0;
        logic [0:0]    w0;
        if (with_wr) mw[wj][wi] = wd;
        model_volley(learn, e);
        sb.push_back(e);
        out_ready = (hold == 0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_times = pack();
        learn_en = learn;
        in_valid = 1'b1;
        if (with_wr) begin
            wr_en     = 1'b1;
            wr_neuron = 1'(wj);
            wr_input  = 2'(wi);
            wr_data   = WB'(wd);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        in_times = '0;        // post-accept changes must not matter
        learn_en = ~learn;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got = sb.pop_front();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_latency"}, 32'(lat), 32'(got.lat));
        check({tag, "_out_time"}, 32'(out_time), 32'(got.t));
        check({tag, "_out_winner"}, 32'(out_winner), 32'(got.w));
        t0 = out_time;
        w0 = out_winner;
        for (int h = 0; h < hold; h++) begin
            wr_en     = 1'b1;   // must be ignored outside IDLE
            wr_neuron = 1'b1;
            wr_input  = 2'd0;
            wr_data   = 3'd0;
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_time"}, 32'(out_time), 32'(t0));
            check({tag, "_hold_winner"}, 32'(out_winner), 32'(w0));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        wr_en     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_times  = '0;
        learn_en  = 1'b0;
        out_ready = 1'b1;
        wr_en     = 1'b0;
        wr_neuron = '0;
        wr_input  = '0;
        wr_data   = '0;
        for (int j = 0; j < Q; j++)
            for (int i = 0; i < P; i++)
                mw[j][i] = WI;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_time", 32'(out_time), 32'h8);
        check("rst_out_winner", 32'(out_winner), 32'd0);
        check_weights("rst_weights");

        // Unit weights: three inputs at t=0 reach THRESH together -> tie at 0.
        sv = '{0, 0, 0, -1};
        run_volley("unit_w", 1'b0, 1'b0, 0, 0, 0, 0);
        check("unit_w_time_const", 32'(out_time), 32'h0);

        // n0 all 3, n1 all 1.
        for (int i = 0; i < P; i++) write_w(0, i, 3);
        for (int i = 0; i < P; i++) write_w(1, i, 1);
        check_weights("wr_weights");

        sv = '{0, 2, 7, -1};
        run_volley("basic", 1'b0, 1'b0, 0, 0, 0, 0);
        check_weights("basic_nolearn");

        run_volley("learn", 1'b1, 1'b0, 0, 0, 0, 0);
        check_weights("learn_weights");
        check("learn_n0_w1", 32'(dut.w_q[0][1]), 32'd2);
        check("learn_n1_w3", 32'(dut.w_q[1][3]), 32'd1);

        // Tie on identical weights.
        for (int j = 0; j < Q; j++)
            for (int i = 0; i < P; i++) write_w(j, i, 3);
        sv = '{1, -1, -1, -1};
        run_volley("tie", 1'b0, 1'b0, 0, 0, 0, 0);
        check("tie_time_const", 32'(out_time), 32'h1);

        // No spikes with learning: no result, weights untouched.
        sv = '{-1, -1, -1, -1};
        run_volley("nospk", 1'b1, 1'b0, 0, 0, 0, 0);
        check("nospk_time_const", 32'(out_time), 32'h8);
        check_weights("nospk_weights");

        // Write in the accept cycle silences n0 input 0, so n1 wins.
        sv = '{0, -1, -1, -1};
        run_volley("wr_accept", 1'b0, 1'b1, 0, 0, 0, 0);
        check("wr_accept_winner_const", 32'(out_winner), 32'd1);

        // Backpressure with ignored writes.
        sv = '{3, 3, 3, 3};
        run_volley("bp", 1'b0, 1'b0, 0, 0, 0, 5);
        check_weights("bp_weights");

        // Reset in the middle of COMPUTE.
        sv = '{0, 1, 2, 3};
        in_times = pack();
        learn_en = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wr_en    = 1'b1;    // ignored while busy
        repeat (3) @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #2;
        for (int j = 0; j < Q; j++)
            for (int i = 0; i < P; i++)
                mw[j][i] = WI;
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_out_time", 32'(out_time), 32'h8);
        check("mrst_out_winner", 32'(out_winner), 32'd0);
        check_weights("mrst_weights");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
